// File: rtl/multi_var_divider_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master drives enables, sync and divisors; the divider drives out and tick.
interface multi_var_divider_if #(
  parameter int W = 8,
  parameter int N = 2
);
  logic [N-1:0]   en;
  logic           sync;
  logic [N*W-1:0] div;
  logic [N-1:0]   out;
  logic [N-1:0]   tick;

  modport master (output en, sync, div, input out, tick);
  modport slave  (input en, sync, div, output out, tick);
endinterface

// File: rtl/multi_var_divider.sv
// N independent clk dividers (period div+1) with shadowed divisors, shared sync,
// and a one-cycle tick at each period start. Outputs are clk-domain data strobes.
module multi_var_divider #(
  parameter int W = 8,
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                reset,
  multi_var_divider_if.slave  bus
);

  logic [N-1:0]   active;
  logic [W-1:0]   shadow [N];
  logic [W-1:0]   count  [N];
  logic [N-1:0]   out_q;
  logic [N-1:0]   tick_q;

  // Low-phase length ceil((s+1)/2), widened so s = 2^W-1 cannot overflow.
  function automatic logic [W:0] low_len(input logic [W-1:0] s);
    logic [W:0] d_plus1;
    d_plus1 = {1'b0, s} + (W+1)'(2);
    return d_plus1 >> 1;
  endfunction

  // NOTE: the per-channel arrays are a handful of flops, not a RAM, so they are
  // reset like any other state; a real memory array would be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        count[i]  <= '0;
      end
      active <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every channel reads the values
      // from before this edge, independent of loop or statement order.
      for (int i = 0; i < N; i++) begin
        if (!bus.en[i]) begin
          active[i] <= 1'b0;
          count[i]  <= '0;
          out_q[i]  <= 1'b0;
          tick_q[i] <= 1'b0;
        end else if (!active[i] || bus.sync || (count[i] == shadow[i])) begin
          // Start of period: the divisor is captured only here.
          active[i] <= 1'b1;
          shadow[i] <= bus.div[i*W +: W];
          count[i]  <= '0;
          out_q[i]  <= 1'b0;
          tick_q[i] <= 1'b1;
        end else begin
          count[i]  <= count[i] + W'(1);
          out_q[i]  <= (({1'b0, count[i]} + (W+1)'(1)) >= low_len(shadow[i]));
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.tick = tick_q;

endmodule
